// File: rtl/wb_stage.sv
// wb_stage: writeback stage with architectural HI/LO, register-file write port and a 4-entry trace FIFO.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_res,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic [31:0] wb_rdata,
  input  logic        wb_load,
  input  logic        wb_al,
  input  logic        wb_regwen,
  input  logic        wb_cp0ren,
  input  logic [5:0]  wb_wreg,
  input  logic [31:0] wb_cp0rdata,
  input  logic [1:0]  wb_rhilo,
  input  logic [1:0]  wb_whilo,
  output logic        wb_stall,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [3:0]  trace_wen,
  output logic [4:0]  trace_wnum,
  output logic [31:0] trace_wdata
);
  logic [31:0] mem_pc [4];
  logic [4:0]  mem_wnum [4];
  logic [31:0] mem_wdata [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count;
  logic        need_wr, retire, push, pop;
  assign need_wr  = wb_valid & wb_regwen & (wb_wreg[4:0] != 5'd0);
  // Stall looks only at the registered count, so a same-cycle pop cannot release it.
  assign wb_stall = need_wr & (count == 3'd4);
  assign retire   = wb_valid & ~wb_stall;
  assign push     = need_wr & ~wb_stall;
  assign pop      = trace_valid & trace_ready;
  assign rf_wen   = push;
  assign rf_waddr = wb_wreg[4:0];
  // HI/LO feed the mux from their registers; a same-cycle MTHI/MTLO is not bypassed.
  always_comb
    rf_wdata = wb_load     ? wb_rdata :
               wb_cp0ren   ? wb_cp0rdata :
               wb_rhilo[1] ? hi :
               wb_rhilo[0] ? lo :
               wb_al       ? wb_pc + 32'd8 : wb_res;
  assign trace_valid = count != 3'd0;
  assign trace_pc    = trace_valid ? mem_pc[rd_ptr] : 32'd0;
  assign trace_wen   = trace_valid ? 4'hF : 4'h0;
  assign trace_wnum  = trace_valid ? mem_wnum[rd_ptr] : 5'd0;
  assign trace_wdata = trace_valid ? mem_wdata[rd_ptr] : 32'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (retire & wb_whilo[1]) hi <= wb_hi;
      if (retire & wb_whilo[0]) lo <= wb_lo;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'd0, push} - {2'd0, pop};
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_pc[wr_ptr]    <= wb_pc;
      mem_wnum[wr_ptr]  <= wb_wreg[4:0];
      mem_wdata[wr_ptr] <= rf_wdata;
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector table plus hand sequences for FIFO-full stall and async reset.
module tb_wb_stage;
  logic        clk = 1'b0, reset;
  logic        wb_valid, wb_load, wb_al, wb_regwen, wb_cp0ren, trace_ready;
  logic [31:0] wb_pc, wb_res, wb_hi, wb_lo, wb_rdata, wb_cp0rdata;
  logic [5:0]  wb_wreg;
  logic [1:0]  wb_rhilo, wb_whilo;
  logic        wb_stall, rf_wen, trace_valid;
  logic [4:0]  rf_waddr, trace_wnum;
  logic [31:0] rf_wdata, hi, lo, trace_pc, trace_wdata;
  logic [3:0]  trace_wen;
  int total = 0, bad = 0;

  wb_stage dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_res(wb_res),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_rdata(wb_rdata), .wb_load(wb_load), .wb_al(wb_al),
    .wb_regwen(wb_regwen), .wb_cp0ren(wb_cp0ren), .wb_wreg(wb_wreg), .wb_cp0rdata(wb_cp0rdata),
    .wb_rhilo(wb_rhilo), .wb_whilo(wb_whilo), .wb_stall(wb_stall), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi(hi), .lo(lo), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_wen(trace_wen),
    .trace_wnum(trace_wnum), .trace_wdata(trace_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid;
    logic [31:0] pc, res, rdata, cp0d;
    logic        load, al, regwen, cp0ren;
    logic [5:0]  wreg;
    logic [1:0]  rhilo, whilo;
    logic [31:0] hin, lin;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ehi, elo;
    logic        tv;
    logic [31:0] tpc, twd;
  } vec_t;

  vec_t v [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drv(input logic valid, input logic [31:0] pc, input logic [31:0] res,
                     input logic [5:0] wreg, input logic [1:0] whilo,
                     input logic [31:0] hin, input logic [31:0] lin);
    wb_valid = valid; wb_pc = pc; wb_res = res; wb_wreg = wreg; wb_whilo = whilo;
    wb_hi = hin; wb_lo = lin; wb_regwen = 1'b1;
    wb_load = 1'b0; wb_al = 1'b0; wb_cp0ren = 1'b0; wb_rhilo = 2'b00;
    wb_rdata = 32'd0; wb_cp0rdata = 32'd0;
  endtask

  initial begin
    // valid pc res rdata cp0d | load al regwen cp0ren | wreg rhilo whilo hin lin || wen waddr wdata stall hi lo | tv tpc twd
    v[0]  = '{1'b1, 32'h1000, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 2'b00, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
    v[1]  = '{1'b1, 32'hBFC00000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd31, 2'b00, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd31, 32'hBFC00008, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1000, 32'hDEADBEEF};
    v[2]  = '{1'b1, 32'h2000, 32'hAAAA, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 6'd7, 2'b00, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd7, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBFC00000, 32'hBFC00008};
    v[3]  = '{1'b1, 32'h3000, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 2'b00, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd3, 32'h55, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2000, 32'h12345678};
    v[4]  = '{1'b1, 32'h4000, 32'h99, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00, 2'b11, 32'h1, 32'h2,
              1'b0, 5'd0, 32'h99, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3000, 32'h55};
    v[5]  = '{1'b1, 32'h5000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd8, 2'b10, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd8, 32'h1, 1'b0, 32'h1, 32'h2, 1'b0, 32'h0, 32'h0};
    v[6]  = '{1'b1, 32'h6000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd9, 2'b01, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd9, 32'h2, 1'b0, 32'h1, 32'h2, 1'b1, 32'h5000, 32'h1};
    v[7]  = '{1'b1, 32'h7000, 32'h0, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 6'd10, 2'b00, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd10, 32'h11, 1'b0, 32'h1, 32'h2, 1'b1, 32'h6000, 32'h2};
    v[8]  = '{1'b1, 32'h8000, 32'h0, 32'h0, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 6'd11, 2'b10, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd11, 32'h33, 1'b0, 32'h1, 32'h2, 1'b1, 32'h7000, 32'h11};
    v[9]  = '{1'b1, 32'h9000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd12, 2'b11, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd12, 32'h1, 1'b0, 32'h1, 32'h2, 1'b1, 32'h8000, 32'h33};
    v[10] = '{1'b1, 32'hA000, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h20, 2'b00, 2'b00, 32'h0, 32'h0,
              1'b0, 5'd0, 32'h44, 1'b0, 32'h1, 32'h2, 1'b1, 32'h9000, 32'h1};
    v[11] = '{1'b1, 32'hB000, 32'h66, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h21, 2'b00, 2'b00, 32'h0, 32'h0,
              1'b1, 5'd1, 32'h66, 1'b0, 32'h1, 32'h2, 1'b0, 32'h0, 32'h0};
    v[12] = '{1'b0, 32'hC000, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4, 2'b00, 2'b11, 32'h77, 32'h88,
              1'b0, 5'd4, 32'h5, 1'b0, 32'h1, 32'h2, 1'b1, 32'hB000, 32'h66};
    v[13] = '{1'b1, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd31, 2'b00, 2'b01, 32'h0, 32'h123,
              1'b1, 5'd31, 32'h4, 1'b0, 32'h1, 32'h2, 1'b0, 32'h0, 32'h0};

    reset = 1'b1;
    trace_ready = 1'b1;
    drv(1'b0, 32'h0, 32'h0, 6'd0, 2'b00, 32'h0, 32'h0);
    wb_regwen = 1'b0;
    #3;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_tvalid", {31'd0, trace_valid}, 32'h0);
    chk("rst_stall", {31'd0, wb_stall}, 32'h0);
    chk("rst_tpc", trace_pc, 32'h0);
    chk("rst_twen", {28'd0, trace_wen}, 32'h0);
    drv(1'b1, 32'h0, 32'h0, 6'd3, 2'b00, 32'h0, 32'h0);
    #1;
    chk("rst_rfwen_comb", {31'd0, rf_wen}, 32'h1);
    chk("rst_rfwaddr", {27'd0, rf_waddr}, 32'h3);
    drv(1'b0, 32'h0, 32'h0, 6'd0, 2'b00, 32'h0, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      wb_valid = v[i].valid; wb_pc = v[i].pc; wb_res = v[i].res; wb_rdata = v[i].rdata;
      wb_cp0rdata = v[i].cp0d; wb_load = v[i].load; wb_al = v[i].al; wb_regwen = v[i].regwen;
      wb_cp0ren = v[i].cp0ren; wb_wreg = v[i].wreg; wb_rhilo = v[i].rhilo; wb_whilo = v[i].whilo;
      wb_hi = v[i].hin; wb_lo = v[i].lin;
      @(negedge clk);
      chk($sformatf("v%0d_rfwen", i), {31'd0, rf_wen}, {31'd0, v[i].wen});
      chk($sformatf("v%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, v[i].waddr});
      chk($sformatf("v%0d_wdata", i), rf_wdata, v[i].wdata);
      chk($sformatf("v%0d_stall", i), {31'd0, wb_stall}, {31'd0, v[i].stall});
      chk($sformatf("v%0d_hi", i), hi, v[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, v[i].elo);
      chk($sformatf("v%0d_tvalid", i), {31'd0, trace_valid}, {31'd0, v[i].tv});
      chk($sformatf("v%0d_tpc", i), trace_pc, v[i].tpc);
      chk($sformatf("v%0d_twdata", i), trace_wdata, v[i].twd);
      chk($sformatf("v%0d_twen", i), {28'd0, trace_wen}, v[i].tv ? 32'hF : 32'h0);
      @(posedge clk); #1;
    end

    drv(1'b0, 32'h0, 32'h0, 6'd0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("jal_wrap_tpc", trace_pc, 32'hFFFFFFFC);
    chk("jal_wrap_twdata", trace_wdata, 32'h4);
    chk("jal_wrap_twnum", {27'd0, trace_wnum}, 32'd31);
    chk("mtlo_lo", lo, 32'h123);
    chk("mtlo_hi_kept", hi, 32'h1);
    @(posedge clk); #1;
    chk("drained", {31'd0, trace_valid}, 32'h0);

    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'hE000 + 32'(4 * i), 32'h100 + 32'(i), 6'(10 + i), 2'b11, 32'hA0 + 32'(i), 32'hB0 + 32'(i));
      @(negedge clk);
      chk($sformatf("fill%0d_stall", i), {31'd0, wb_stall}, 32'h0);
      chk($sformatf("fill%0d_rfwen", i), {31'd0, rf_wen}, 32'h1);
      @(posedge clk); #1;
    end
    drv(1'b1, 32'hE010, 32'h104, 6'd14, 2'b11, 32'hA4, 32'hB4);
    @(negedge clk);
    chk("full_stall", {31'd0, wb_stall}, 32'h1);
    chk("full_rfwen", {31'd0, rf_wen}, 32'h0);
    chk("full_head_pc", trace_pc, 32'hE000);
    chk("full_head_wnum", {27'd0, trace_wnum}, 32'd10);
    @(posedge clk); #1;
    chk("frozen_hi", hi, 32'hA3);
    chk("frozen_lo", lo, 32'hB3);
    drv(1'b1, 32'hF000, 32'h0, 6'd0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("r0_full_stall", {31'd0, wb_stall}, 32'h0);
    chk("r0_full_rfwen", {31'd0, rf_wen}, 32'h0);
    @(posedge clk); #1;
    drv(1'b1, 32'hE010, 32'h104, 6'd14, 2'b11, 32'hA4, 32'hB4);
    trace_ready = 1'b1;
    @(negedge clk);
    chk("pop_full_stall", {31'd0, wb_stall}, 32'h1);
    chk("pop_full_rfwen", {31'd0, rf_wen}, 32'h0);
    chk("still_frozen_hi", hi, 32'hA3);
    @(posedge clk); #1;
    chk("release_stall", {31'd0, wb_stall}, 32'h0);
    chk("release_rfwen", {31'd0, rf_wen}, 32'h1);
    chk("release_wdata", rf_wdata, 32'h104);
    chk("release_head_pc", trace_pc, 32'hE004);
    @(posedge clk); #1;
    chk("retired_hi", hi, 32'hA4);
    chk("retired_lo", lo, 32'hB4);
    chk("pushpop_head_pc", trace_pc, 32'hE008);
    trace_ready = 1'b0;
    drv(1'b0, 32'h0, 32'h0, 6'd0, 2'b00, 32'h0, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("async_tvalid", {31'd0, trace_valid}, 32'h0);
    chk("async_hi", hi, 32'h0);
    chk("async_lo", lo, 32'h0);
    chk("async_tpc", trace_pc, 32'h0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_tvalid", {31'd0, trace_valid}, 32'h0);
    chk("post_rst_stall", {31'd0, wb_stall}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The module SHALL use one clock and an asynchronous active-high reset, with ports listed as name  direction  width  meaning:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
REQ-002 The module SHALL have the following pipeline-side ports (fields of the MEM/WB register):
- wb_valid  in  1  instruction present in WB.
- wb_pc  in  32  instruction PC.
- wb_res  in  32  ALU result.
- wb_hi, wb_lo  in  32 each  HI/LO write values.
- wb_rdata  in  32  load data.
- wb_load, wb_al, wb_regwen, wb_cp0ren  in  1 each  instruction class and enable flags.
- wb_wreg  in  6  destination; bits [4:0] used, bit 5 ignored.
- wb_cp0rdata  in  32  CP0 read data.
- wb_rhilo, wb_whilo  in  2 each  bit1=HI, bit0=LO.
REQ-003 The module SHALL have the following output ports:
- wb_stall  out  1  WB cannot retire this cycle.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- hi, lo  out  32 each  architectural HI and LO.
REQ-004 The module SHALL have the following trace ports:
- trace_valid  out  1  trace entry available.
- trace_ready  in  1  consumer accepts the entry.
- trace_pc  out  32  traced PC.
- trace_wen  out  4  traced write-byte enable.
- trace_wnum  out  5  traced register number.
- trace_wdata  out  32  traced write data.

Function
REQ-005 The write-data mux SHALL apply this priority: wb_load->wb_rdata; wb_cp0ren->wb_cp0rdata; wb_rhilo[1]->hi; wb_rhilo[0]->lo; wb_al->wb_pc+8 (mod 2^32); otherwise wb_res.
REQ-006 The HI/LO source for the mux SHALL be the registered value before any update in the same cycle; no internal bypass.
REQ-007 The write candidate SHALL be defined as need_wr = wb_valid & wb_regwen & (wb_wreg[4:0] != 0).
REQ-008 The retire condition SHALL be defined as retire = wb_valid & ~wb_stall.
REQ-009 rf_wen SHALL equal need_wr & ~wb_stall, combinationally.
REQ-010 rf_waddr SHALL equal wb_wreg[4:0], combinationally.
REQ-011 rf_wdata SHALL equal the mux output, combinationally.
REQ-012 On retire, wb_whilo[1] SHALL load hi <= wb_hi and wb_whilo[0] SHALL load lo <= wb_lo, independently, at that edge.
REQ-013 On a stalled cycle, HI and LO SHALL remain unchanged.
REQ-014 The trace path SHALL be a 4-entry FIFO with 2-bit read/write pointers wrapping 3->0 and a 3-bit count in 0..4.
REQ-015 The FIFO push condition SHALL be need_wr & ~wb_stall; the entry is {wb_pc, 4'hF, wb_wreg[4:0], mux data}.
REQ-016 The FIFO pop condition SHALL be trace_valid & trace_ready.
REQ-017 trace_valid SHALL equal (count != 0), and the trace_* data ports SHALL present the head entry combinationally.
REQ-018 wb_stall SHALL equal need_wr & (count == 4), using the registered count only.
REQ-019 A pop occurring in a full cycle SHALL NOT clear that cycle's stall.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 A push at full SHALL be impossible by construction; a pop at empty SHALL be ignored.
REQ-022 Instructions with need_wr=0 SHALL never stall and SHALL retire in the same cycle.
REQ-023 Latency: rf write happens in the retire cycle; the trace entry becomes visible in the cycle after the push.

Reset
REQ-024 While reset is high, outputs SHALL be: hi=0, lo=0, count=0, both pointers=0, trace_valid=0, wb_stall=0.
REQ-025 While reset is high, storage array contents SHALL be don't-care, but trace data ports SHALL read 0 when count=0.
REQ-026 Reset asserted mid-operation SHALL immediately discard all FIFO entries and zero HI/LO, independent of clk.
REQ-027 rf_wen SHALL remain combinational from its inputs during reset.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Load wb_load=1, wb_rdata=0xDEADBEEF, wreg=5, trace_ready=1 -> rf_wen=1, waddr=5, wdata=0xDEADBEEF; next cycle trace_pc=wb_pc, trace_wnum=5.
- JAL wb_al=1, wb_pc=0xBFC00000, wreg=31 -> rf_wdata=0xBFC00008.
- MTHI/MTLO wb_whilo=2'b11, wb_hi=1, wb_lo=2, then MFHI wb_rhilo=2'b10 -> hi=1, lo=2 after the edge; MFHI writes 1.
- Write to $0 (wreg=0, regwen=1) -> rf_wen=0, no push, no stall even when FIFO full.
- trace_ready=0 for 5 consecutive writes -> 4 entries accepted; 5th cycle wb_stall=1, rf_wen=0, HI/LO frozen; ready=1 -> stall still 1 that cycle, clears next cycle, 5th write retires.
- Async reset pulse between clock edges with 3 entries queued -> trace_valid=0 and hi=lo=0 before the next edge.
